xc_rf_wb: RTL
=============

// Module: xc_rf_wb
//
// PURPOSE
//  Writeback sequencer and sole driver of the register-file write port.
//  Arbitrates result writes from two producers: p0 is the single-cycle ALU, p1 is the multi-cycle ISE/crypto unit.
//  Legalises every write for the odd/even-banked register file:
//  - aligned (even rd) wide writes issue in one beat;
//  - odd-rd wide writes are split into two narrow beats.
//  Sits between the execute stage and the register file.
//
// PARAMETERS
//  STARVE_LIMIT  4   consecutive cycles p1 may wait while losing to p0 before p1 takes priority
//
// PORTS
//  clock        in   1   core clock
//  resetn       in   1   asynchronous active-low reset
//  p0_valid     in   1   ALU result valid
//  p0_ready     out  1   ALU result accepted this cycle
//  p0_wide      in   1   write rd,rd+1 = {hi,lo}
//  p0_addr      in   5   destination rd
//  p0_lo        in   32  low word, written to rd
//  p0_hi        in   32  high word, written to rd+1 when p0_wide
//  p1_*         --   --  identical set for the ISE unit
//  rd_wen       out  1   register-file write enable
//  rd_wide      out  1   paired write: even rd gets rd_wdata, rd+1 gets rd_wdata_hi
//  rd_addr      out  5   register-file write address
//  rd_wdata     out  32  write data, rd
//  rd_wdata_hi  out  32  write data, rd+1 (valid only with rd_wide)
//  pend_mask    out  32  bit n set while a write to xn is held inside this block
//
// BEHAVIOUR
//  Reset:
//  - all rd_* outputs and pend_mask are 0.
//  - state is PASS; the starve counter is 0.
//  Handshake:
//  - A transfer occurs when pX_valid && pX_ready.
//  - pX_ready is combinational and never depends on pX_valid; at most one ready is high per cycle.
//  - A producer holds all payload stable while it is valid and not ready.
//  Latency:
//  - the rd_* outputs are registered.
//  - A beat accepted in cycle N appears on the rd_* port in cycle N+1, for exactly one cycle.
//  Arbitration, in state PASS:
//  - p0 wins by default.
//  - The starve counter increments each cycle p1_valid is high and p1 is not granted, saturating at STARVE_LIMIT.
//  - While the counter equals STARVE_LIMIT, p1 wins.
//  - The counter clears when p1 is granted or p1_valid is low.
//  States:
//  - PASS -> SPLIT on accepting a wide write with addr[0]=1 and addr != 31.
//  - SPLIT -> PASS unconditionally after one cycle.
//  - In SPLIT both readys are 0 and the starve counter holds.
//  Beat formation:
//  - Narrow, or wide with even addr: one beat with rd_wide = wide, rd_addr = addr, rd_wdata = lo, rd_wdata_hi = hi.
//  - Wide with odd addr (A): beat 1 is rd_wide=0, rd_addr=A, rd_wdata=lo; beat 2, in the cycle after beat 1, is rd_wide=0, rd_addr=A+1, rd_wdata=hi.
//  - The hi word is held in an internal register during SPLIT.
//  - Wide with addr=31: a single beat writes x31 with lo; hi is discarded; no SPLIT.
//  x0 handling:
//  - A narrow write to x0 completes its handshake but produces rd_wen=0 and no pend_mask bit.
//  - A wide write to x0 issues normally: the bank hardwires x0, so only x1 changes.
//  pend_mask:
//  - Set bit(s) for a beat from the cycle after acceptance until that beat's rd_wen cycle ends.
//  - Both bits of a wide or split write are set together.
//  - A split write clears bit A after beat 1 and bit A+1 after beat 2.
//  Idle: rd_wen=0 whenever no beat is issued; rd_addr and rd_wdata hold their last values.
//  Reset asserted mid-SPLIT: the pending hi beat is dropped and all state returns to reset values.
//
// STRUCTURE
//  Shared include xc_rf_defines.vh:
//  - XLEN (32) and RF_AW (5).
//  - State encodings XC_WB_PASS and XC_WB_SPLIT.
//  Sub-module xc_rf_wb_arb contains the two-way priority arbiter with starve counter.
//  - Inputs: clock, resetn, p0_valid, p1_valid, hold.
//  - Outputs: grant0, grant1.
//  Top level contains the payload mux, split FSM, output registers and pend_mask logic.
//
// TESTING
//  1. p0 narrow x5=0x11111111 -> next cycle rd_wen=1, rd_addr=5, rd_wide=0, rd_wdata=0x11111111; pend_mask=0x20 for one cycle.
//  2. p0 wide x6, lo=0xA, hi=0xB -> one beat: rd_wide=1, rd_addr=6, rd_wdata=0xA, rd_wdata_hi=0xB.
//  3. p1 wide x7, lo=0xA, hi=0xB -> beat 1 rd_addr=7 data 0xA, then beat 2 rd_addr=8 data 0xB; both readys low for one cycle.
//  4. p1 wide x31 -> single beat rd_addr=31 data=lo; no stall.
//  5. p0 narrow x0 -> p0_ready=1 but rd_wen stays 0 and pend_mask stays 0.
//  6. p0 and p1 valid every cycle (STARVE_LIMIT=4) -> p1 granted on the 5th cycle after it asserts valid.
//  7. Reset pulse during SPLIT -> rd_wen=0 and pend_mask=0; beat 2 never appears.

Source files
------------

// File: rtl/xc_rf_wb_pkg.sv
// xc_rf_wb_pkg
//   Shared widths, writeback FSM encodings, the producer payload record and a
//   helper that turns a register index into a one-hot pend_mask bit.
package xc_rf_wb_pkg;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  localparam logic [0:0] XC_WB_PASS  = 1'b0;
  localparam logic [0:0] XC_WB_SPLIT = 1'b1;

  typedef struct packed {
    logic             wide;
    logic [RF_AW-1:0] addr;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  hi;
  } wb_req_t;

  function automatic logic [XLEN-1:0] reg_bit(input logic [RF_AW-1:0] a);
    reg_bit = {{(XLEN-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/xc_rf_wb_arb.sv
// xc_rf_wb_arb
//   Two-way priority arbiter: p0 (ALU) wins by default, p1 (ISE) wins once it
//   has waited STARVE_LIMIT consecutive cycles.
//   Ports:
//     clock, resetn      core clock, async active-low reset
//     p0_valid, p1_valid producer requests
//     hold               freeze: no grants, starve counter holds
//     grant0, grant1     combinational readys, mutually exclusive
module xc_rf_wb_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic p0_valid,
  input  logic p1_valid,
  input  logic hold,
  output logic grant0,
  output logic grant1
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve;

  // A ready may not depend on its own valid and the two readys are exclusive,
  // so neither grant can look at p0_valid: p1 only gets the port by starving.
  logic unused_p0_valid;
  assign unused_p0_valid = p0_valid;

  assign starve = (cnt_q == CW'(STARVE_LIMIT));
  assign grant0 = !hold && !starve;
  assign grant1 = !hold &&  starve;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      if (p1_valid && !grant1) begin
        if (!starve) cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/xc_rf_wb.sv
// xc_rf_wb
//   Writeback sequencer and sole driver of the register-file write port.
//   Accepts results from p0 (ALU) and p1 (ISE), legalises wide writes for the
//   odd/even-banked file (odd rd wide writes become two narrow beats) and
//   publishes the registers with writes still in flight on pend_mask.
//   Ports:
//     clock, resetn                 core clock, async active-low reset
//     pX_valid/ready                producer handshake (ready is combinational)
//     pX_wide/addr/lo/hi            producer payload
//     rd_wen/wide/addr/wdata/hi     registered register-file write port
//     pend_mask                     bit n set while a write to xn is held here
//
//   state       | meaning
//   XC_WB_PASS  | normal: accept one result per cycle, issue it next cycle
//   XC_WB_SPLIT | issuing hi beat of an odd-rd wide write; both readys low
module xc_rf_wb
  import xc_rf_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic             p0_wide,
  input  logic [RF_AW-1:0] p0_addr,
  input  logic [XLEN-1:0]  p0_lo,
  input  logic [XLEN-1:0]  p0_hi,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic             p1_wide,
  input  logic [RF_AW-1:0] p1_addr,
  input  logic [XLEN-1:0]  p1_lo,
  input  logic [XLEN-1:0]  p1_hi,
  output logic             rd_wen,
  output logic             rd_wide,
  output logic [RF_AW-1:0] rd_addr,
  output logic [XLEN-1:0]  rd_wdata,
  output logic [XLEN-1:0]  rd_wdata_hi,
  output logic [XLEN-1:0]  pend_mask
);

  logic [0:0]       state_q, state_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [RF_AW-1:0] split_addr_q, split_addr_d;
  logic             rd_wen_q, rd_wen_d;
  logic             rd_wide_q, rd_wide_d;
  logic [RF_AW-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  rd_wdata_q, rd_wdata_d;
  logic [XLEN-1:0]  rd_wdata_hi_q, rd_wdata_hi_d;
  logic [XLEN-1:0]  pend_q, pend_d;

  logic             hold;
  logic             take0, take1;
  wb_req_t          req;
  logic [RF_AW-1:0] addr_p1;

  assign hold = (state_q == XC_WB_SPLIT);

  xc_rf_wb_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clock    (clock),
    .resetn   (resetn),
    .p0_valid (p0_valid),
    .p1_valid (p1_valid),
    .hold     (hold),
    .grant0   (p0_ready),
    .grant1   (p1_ready)
  );

  assign take0 = p0_valid && p0_ready;
  assign take1 = p1_valid && p1_ready;

  always_comb begin
    if (take1) req = '{wide: p1_wide, addr: p1_addr, lo: p1_lo, hi: p1_hi};
    else       req = '{wide: p0_wide, addr: p0_addr, lo: p0_lo, hi: p0_hi};
  end

  assign addr_p1 = req.addr + RF_AW'(1);

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    split_addr_d  = split_addr_q;
    rd_wen_d      = 1'b0;
    rd_wide_d     = rd_wide_q;
    rd_addr_d     = rd_addr_q;
    rd_wdata_d    = rd_wdata_q;
    rd_wdata_hi_d = rd_wdata_hi_q;
    pend_d        = '0;
    if (hold) begin
      rd_wen_d   = 1'b1;
      rd_wide_d  = 1'b0;
      rd_addr_d  = split_addr_q;
      rd_wdata_d = hi_q;
      pend_d     = reg_bit(split_addr_q);
      state_d    = XC_WB_PASS;
    end else if (take0 || take1) begin
      if (!req.wide) begin
        // narrow x0 completes the handshake but never reaches the file
        if (req.addr != '0) begin
          rd_wen_d      = 1'b1;
          rd_wide_d     = 1'b0;
          rd_addr_d     = req.addr;
          rd_wdata_d    = req.lo;
          rd_wdata_hi_d = req.hi;
          pend_d        = reg_bit(req.addr);
        end
      end else if (!req.addr[0]) begin
        rd_wen_d      = 1'b1;
        rd_wide_d     = 1'b1;
        rd_addr_d     = req.addr;
        rd_wdata_d    = req.lo;
        rd_wdata_hi_d = req.hi;
        pend_d        = reg_bit(req.addr) | reg_bit(addr_p1);
      end else if (req.addr == RF_AW'(31)) begin
        // no x32 exists: the hi word is dropped
        rd_wen_d   = 1'b1;
        rd_wide_d  = 1'b0;
        rd_addr_d  = req.addr;
        rd_wdata_d = req.lo;
        pend_d     = reg_bit(req.addr);
      end else begin
        rd_wen_d     = 1'b1;
        rd_wide_d    = 1'b0;
        rd_addr_d    = req.addr;
        rd_wdata_d   = req.lo;
        pend_d       = reg_bit(req.addr) | reg_bit(addr_p1);
        hi_d         = req.hi;
        split_addr_d = addr_p1;
        state_d      = XC_WB_SPLIT;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= XC_WB_PASS;
      hi_q          <= '0;
      split_addr_q  <= '0;
      rd_wen_q      <= 1'b0;
      rd_wide_q     <= 1'b0;
      rd_addr_q     <= '0;
      rd_wdata_q    <= '0;
      rd_wdata_hi_q <= '0;
      pend_q        <= '0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      split_addr_q  <= split_addr_d;
      rd_wen_q      <= rd_wen_d;
      rd_wide_q     <= rd_wide_d;
      rd_addr_q     <= rd_addr_d;
      rd_wdata_q    <= rd_wdata_d;
      rd_wdata_hi_q <= rd_wdata_hi_d;
      pend_q        <= pend_d;
    end
  end

  assign rd_wen      = rd_wen_q;
  assign rd_wide     = rd_wide_q;
  assign rd_addr     = rd_addr_q;
  assign rd_wdata    = rd_wdata_q;
  assign rd_wdata_hi = rd_wdata_hi_q;
  assign pend_mask   = pend_q;

endmodule
